// File: rtl/adsr_poly_if.sv
// adsr_poly_if: sample-strobe / result-stream bundle for adsr_poly.
//   master (envelope generator): takes sample_strobe, drives out/out_voice/out_valid
//   slave  (sequencer + VCA side): drives sample_strobe, takes the result stream
//   sample_strobe : one-cycle pulse per audio sample, starts a sweep
//   out           : amplitude of voice out_voice
//   out_voice     : voice index of out
//   out_valid     : out/out_voice valid this cycle
interface adsr_poly_if #(
    parameter int VOICES         = 8,
    parameter int AMPLITUDE_BITS = 16
);
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic                      sample_strobe;
    logic [AMPLITUDE_BITS-1:0] out;
    logic [VW-1:0]             out_voice;
    logic                      out_valid;

    modport master (input sample_strobe, output out, output out_voice, output out_valid);
    modport slave  (output sample_strobe, input out, input out_voice, input out_valid);
endinterface

// File: rtl/adsr_poly.sv
// adsr_poly: time-multiplexed ADSR envelope generator for VOICES voices.
// One shared datapath services voice 0..VOICES-1, one per cycle, after each
// accepted sample strobe; per-voice stage and level live in state arrays.
// Optional feature macro: ADSR_POLY_VELOCITY_EN (per-voice 8-bit velocity
// scaling of out, one extra output pipeline stage).
// Ports:
//   clk, reset (async, active low)
//   bus          : adsr_poly_if.master (sample_strobe in; out/out_voice/out_valid)
//   attack_time, decay_time, release_time : per-sample level steps (>= 0)
//   sustain      : sustain level, 0..1.0
//   gate         : per-voice gate
//   velocity     : per-voice 8-bit velocity (only with ADSR_POLY_VELOCITY_EN)
//   active       : bit v high while voice v is not IDLE
//   busy         : sweep in progress
//   overrun      : sticky, strobe arrived while busy
package mypackage;
    localparam int AMPLITUDE_BITS = 16;
    typedef logic [AMPLITUDE_BITS-1:0] amplitude;
endpackage

module adsr_poly
    import mypackage::*;
#(
    parameter int VOICES          = 8,
    parameter int TOTAL_BITS      = 48,
    parameter int FRACTIONAL_BITS = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    adsr_poly_if.master                  bus,
    input  logic signed [TOTAL_BITS-1:0] attack_time,
    input  logic signed [TOTAL_BITS-1:0] decay_time,
    input  logic signed [TOTAL_BITS-1:0] release_time,
    input  logic signed [TOTAL_BITS-1:0] sustain,
    input  logic [VOICES-1:0]            gate,
`ifdef ADSR_POLY_VELOCITY_EN
    input  logic [VOICES*8-1:0]          velocity,
`endif
    output logic [VOICES-1:0]            active,
    output logic                         busy,
    output logic                         overrun
);
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int TB = TOTAL_BITS;
    localparam int FB = FRACTIONAL_BITS;
    localparam int AB = AMPLITUDE_BITS;
`ifdef ADSR_POLY_VELOCITY_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif
    localparam logic [TB:0] ONE = {{TB{1'b0}}, 1'b1} << FB;

    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} stage_t;
    typedef struct packed {
        stage_t        stage;
        logic [TB-1:0] level;
    } voice_t;
    typedef enum logic {SW_IDLE, SW_RUN} sweep_t;

    // ---------------- sweep sequencer ----------------
    sweep_t          sw_q, sw_d;
    logic [VW-1:0]   idx_q, idx_d;
    logic [STAGES:0] vld_pipe;   // [0] = service cycle, [STAGES] = out_valid
    logic            svc;

    assign svc           = (sw_q == SW_RUN);
    assign busy          = |vld_pipe;
    assign bus.out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_q     <= SW_IDLE;
            idx_q    <= '0;
            vld_pipe <= '0;
            overrun  <= 1'b0;
        end else begin
            sw_q     <= sw_d;
            idx_q    <= idx_d;
            vld_pipe <= {vld_pipe[STAGES-1:0], sw_d == SW_RUN};
            if (bus.sample_strobe && busy)
                overrun <= 1'b1;
        end
    end

    // busy covers the trailing output cycles too, so a strobe is only taken
    // once the previous sweep has fully drained.
    always_comb begin
        sw_d  = sw_q;
        idx_d = idx_q;
        case (sw_q)
            SW_IDLE: if (bus.sample_strobe && !busy) begin
                sw_d  = SW_RUN;
                idx_d = '0;
            end
            SW_RUN: begin
                if (idx_q == VW'(VOICES - 1))
                    sw_d = SW_IDLE;
                else
                    idx_d = idx_q + VW'(1);
            end
            default: sw_d = SW_IDLE;
        endcase
    end

    // ---------------- per-voice state ----------------
    voice_t vs [VOICES];
    voice_t cur, nxt;
    stage_t eff;
    logic   g;
    logic [TB:0] sum, dif_d, dif_r;
    amplitude    amp_n;
`ifdef ADSR_POLY_VELOCITY_EN
    logic [7:0] vel_q [VOICES];
    logic [7:0] vel_n;
`endif

    // Shared datapath: gate override first, then the step of the resulting
    // stage, so entering ATTACK/RELEASE applies that stage's step this service.
    // Arithmetic is one bit wider than the level so nothing wraps.
    always_comb begin
        cur = vs[idx_q];
        g   = gate[idx_q];
        eff = cur.stage;
        case (cur.stage)
            IDLE, RELEASE:          if (g)  eff = ATTACK;
            ATTACK, DECAY, SUSTAIN: if (!g) eff = RELEASE;
            default:                eff = IDLE;
        endcase
        sum   = {1'b0, cur.level} + {1'b0, attack_time};
        dif_d = {1'b0, cur.level} - {1'b0, decay_time};
        dif_r = {1'b0, cur.level} - {1'b0, release_time};
        nxt       = cur;
        nxt.stage = eff;
        case (eff)
            ATTACK: begin
                if (sum >= ONE) begin
                    nxt.level = ONE[TB-1:0];
                    nxt.stage = DECAY;
                end else
                    nxt.level = sum[TB-1:0];
            end
            DECAY: begin
                if ($signed(dif_d) <= $signed({sustain[TB-1], sustain})) begin
                    nxt.level = sustain;
                    nxt.stage = SUSTAIN;
                end else
                    nxt.level = dif_d[TB-1:0];
            end
            SUSTAIN: nxt.level = sustain;   // follows live sustain changes
            RELEASE: begin
                if ($signed(dif_r) <= $signed({(TB+1){1'b0}})) begin
                    nxt.level = '0;
                    nxt.stage = IDLE;
                end else
                    nxt.level = dif_r[TB-1:0];
            end
            default: nxt = cur;
        endcase
        // 1.0 has no representation in the fraction field: saturate.
        amp_n = (|nxt.level[TB-1:FB]) ? '1 : nxt.level[FB-1 -: AB];
`ifdef ADSR_POLY_VELOCITY_EN
        vel_n = ((cur.stage == IDLE || cur.stage == RELEASE) && g)
              ? velocity[{idx_q, 3'b000} +: 8] : vel_q[idx_q];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < VOICES; i++) begin
                vs[i] <= '0;
`ifdef ADSR_POLY_VELOCITY_EN
                vel_q[i] <= '0;
`endif
            end
            active <= '0;
        end else if (svc) begin
            vs[idx_q]     <= nxt;
            active[idx_q] <= (nxt.stage != IDLE);
`ifdef ADSR_POLY_VELOCITY_EN
            vel_q[idx_q]  <= vel_n;
`endif
        end
    end

    // ---------------- output stage(s) ----------------
`ifdef ADSR_POLY_VELOCITY_EN
    amplitude      amp_q;
    logic [7:0]    velp_q;
    logic [VW-1:0] voice_q;
    logic [AB+8:0] prod;

    assign prod = (AB+9)'(amp_q) * (AB+9)'({1'b0, velp_q} + 9'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            amp_q         <= '0;
            velp_q        <= '0;
            voice_q       <= '0;
            bus.out       <= '0;
            bus.out_voice <= '0;
        end else begin
            if (svc) begin
                amp_q   <= amp_n;
                velp_q  <= vel_n;
                voice_q <= idx_q;
            end
            if (vld_pipe[1]) begin
                bus.out       <= prod[AB+7:8];
                bus.out_voice <= voice_q;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out       <= '0;
            bus.out_voice <= '0;
        end else if (svc) begin
            bus.out       <= amp_n;
            bus.out_voice <= idx_q;
        end
    end
`endif
endmodule

// File: tb/tb_adsr_poly.sv
// tb_adsr_poly: directed, table-driven bench for adsr_poly with VOICES=4,
// 48/32 fixed point, step = 2^32/100, sustain = 0.5.
module tb_adsr_poly;
    localparam int VOICES = 4;
    localparam logic [47:0] STEP = 48'd42949672;
    localparam logic [47:0] SUS  = 48'h0000_8000_0000;

    logic clk = 1'b0;
    logic reset;
    logic signed [47:0] attack_time, decay_time, release_time, sustain;
    logic [VOICES-1:0] gate;
    logic [VOICES-1:0] active;
    logic busy, overrun;

    adsr_poly_if #(.VOICES(VOICES)) bus ();

    adsr_poly #(.VOICES(VOICES), .TOTAL_BITS(48), .FRACTIONAL_BITS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .attack_time  (attack_time),
        .decay_time   (decay_time),
        .release_time (release_time),
        .sustain      (sustain),
        .gate         (gate),
        .active       (active),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] amp_v [VOICES];
    bit timing_ok;
    logic [15:0] h0 [230];
    logic [15:0] h3 [230];

    typedef struct {
        logic [3:0]  gate;
        int          n;      // sweeps to run with this gate
        logic [15:0] amp2;   // voice 2 amplitude after the last sweep
        logic [3:0]  act;
    } vec_t;
    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One strobe and the full sweep; exact cycle positions of busy/out_valid
    // are folded into timing_ok, amplitudes land in amp_v.
    task automatic do_sweep();
        timing_ok = 1'b1;
        @(negedge clk); bus.sample_strobe = 1'b1;
        @(negedge clk); bus.sample_strobe = 1'b0;
        if (!busy || bus.out_valid) timing_ok = 1'b0;
        for (int k = 1; k <= VOICES + 1; k++) begin
            @(negedge clk);
            if (k <= VOICES) begin
                if (!bus.out_valid || bus.out_voice != 2'(k - 1) || !busy) timing_ok = 1'b0;
                amp_v[k-1] = bus.out;
            end else if (busy || bus.out_valid) timing_ok = 1'b0;
        end
    endtask

    initial begin
        int mism, others, nvalid;
        tbl[0]  = '{4'b0000,   1, 16'h0000, 4'b0000};
        tbl[1]  = '{4'b0100,   1, 16'h028F, 4'b0100};
        tbl[2]  = '{4'b0100,  99, 16'hFFFF, 4'b0100};
        tbl[3]  = '{4'b0100,   1, 16'hFFFF, 4'b0100};
        tbl[4]  = '{4'b0100,   1, 16'hFD70, 4'b0100};
        tbl[5]  = '{4'b0100,  99, 16'h8000, 4'b0100};
        tbl[6]  = '{4'b0000,   1, 16'h7D70, 4'b0100};
        tbl[7]  = '{4'b0000,  49, 16'h0000, 4'b0100};
        tbl[8]  = '{4'b0000,   1, 16'h0000, 4'b0000};
        tbl[9]  = '{4'b0100, 152, 16'h8000, 4'b0100};
        tbl[10] = '{4'b0000,  24, 16'h428F, 4'b0100};
        tbl[11] = '{4'b0100,   1, 16'h451E, 4'b0100};
        tbl[12] = '{4'b0100,  74, 16'hFFFF, 4'b0100};
        tbl[13] = '{4'b0100,   1, 16'hFD70, 4'b0100};
        tbl[14] = '{4'b0000, 100, 16'h0000, 4'b0000};

        reset = 1'b0;
        gate = '0;
        bus.sample_strobe = 1'b0;
        attack_time = STEP; decay_time = STEP; release_time = STEP; sustain = SUS;
        repeat (3) @(negedge clk);
        check("rst_out", bus.out, 0);
        check("rst_out_voice", bus.out_voice, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_active", active, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;

        // ADSR walk on voice 2, release, retrigger mid-release
        for (int e = 0; e < 15; e++) begin
            gate = tbl[e].gate;
            for (int n = 0; n < tbl[e].n; n++) do_sweep();
            for (int v = 0; v < VOICES; v++)
                check($sformatf("vec%0d_amp%0d", e, v), amp_v[v], (v == 2) ? tbl[e].amp2 : 16'h0000);
            check($sformatf("vec%0d_active", e), active, tbl[e].act);
            check($sformatf("vec%0d_timing", e), timing_ok, 1);
        end

        // voice 3 opened 30 sweeps after voice 0 must trace the same envelope
        mism = 0; others = 0;
        gate = 4'b0001;
        for (int n = 0; n < 230; n++) begin
            if (n == 30) gate = 4'b1001;
            do_sweep();
            h0[n] = amp_v[0];
            h3[n] = amp_v[3];
            if (amp_v[1] != 0 || amp_v[2] != 0) others++;
        end
        for (int n = 0; n < 230; n++)
            if (h3[n] != ((n < 30) ? 16'h0000 : h0[n-30])) mism++;
        check("indep_delay_mismatches", mism, 0);
        check("indep_others_nonzero", others, 0);
        check("indep_v0_first", h0[0], 16'h028F);
        check("indep_v3_first", h3[30], 16'h028F);
        check("indep_v0_peak", h0[100], 16'hFFFF);
        check("indep_v3_sustain", h3[229], 16'h8000);
        gate = '0;
        repeat (60) do_sweep();
        check("indep_released", active, 0);

        // overrun: second strobe 3 cycles in is dropped; strobe as busy falls is taken
        nvalid = 0;
        @(negedge clk); bus.sample_strobe = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.out_valid) nvalid++;
            if (c == 4) check("overrun_set", overrun, 1);
            if (c == 6) check("busy_fall", busy, 0);
            if (c == 7) check("accept_at_fall", busy, 1);
            if (c == 8) check("second_sweep_v0", {bus.out_valid, bus.out_voice}, 3'b100);
            bus.sample_strobe = (c == 3 || c == 6);
        end
        check("overrun_valid_count", nvalid, 8);
        check("overrun_sticky", overrun, 1);

        // asynchronous reset in the middle of a sweep
        gate = 4'b0100;
        repeat (5) do_sweep();
        check("pre_rst_amp2", amp_v[2], 16'h0CCC);
        check("pre_rst_active", active, 4'b0100);
        @(negedge clk); bus.sample_strobe = 1'b1;
        @(negedge clk); bus.sample_strobe = 1'b0;
        @(negedge clk);
        check("mid_sweep_valid", bus.out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_out", bus.out, 0);
        check("async_rst_out_voice", bus.out_voice, 0);
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_active", active, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_overrun", overrun, 0);
        gate = '0;
        @(negedge clk); reset = 1'b1;
        do_sweep();
        check("post_rst_timing", timing_ok, 1);
        for (int v = 0; v < VOICES; v++)
            check($sformatf("post_rst_amp%0d", v), amp_v[v], 0);
        check("post_rst_active", active, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
